// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: serializes one command into frame bytes and assembles the response word.
// Optional response watchdog enabled by defining UART_CMD_MASTER_TIMEOUT_EN.
module uart_cmd_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RSP_WIDTH  = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_WIDTH-1:0] cmd_opa,
  input  logic [DATA_WIDTH-1:0] cmd_opb,
  input  logic [3:0]            cmd_fun,
  output logic [DATA_WIDTH-1:0] tx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_byte,
  input  logic                  rx_valid,
  output logic                  rsp_valid,
  output logic [RSP_WIDTH-1:0]  rsp_data,
  output logic                  rsp_timeout
);

  localparam int unsigned RSP_BYTES = RSP_WIDTH / DATA_WIDTH;
  localparam int unsigned BCNT_W    = $clog2(RSP_BYTES + 1);

  localparam logic [1:0] CMD_RF_WR  = 2'd0;
  localparam logic [1:0] CMD_RF_RD  = 2'd1;
  localparam logic [1:0] CMD_ALU_OP = 2'd2;

  localparam logic [DATA_WIDTH-1:0] HDR_RF_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] HDR_RF_RD   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] HDR_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] HDR_ALU_NOP = DATA_WIDTH'(8'hDD);

  // Reject parameter sets the byte lanes and watchdog cannot represent.
  if (TIMEOUT < 2 || (RSP_WIDTH % DATA_WIDTH) != 0 || ADDR_WIDTH > DATA_WIDTH) begin : g_bad_params
    $error("uart_cmd_master: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RSP, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]            typ;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic [3:0]            fun;
  } cmd_t;

  state_t                state, state_nxt;
  cmd_t                  cmd_in, cmd_q, cmd_nxt;
  logic [1:0]            idx_q, idx_nxt;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_nxt;
  logic [RSP_WIDTH-1:0]  acc_q, acc_nxt;
  logic                  cmd_ready_nxt;
  logic                  tx_valid_nxt;
  logic [DATA_WIDTH-1:0] tx_byte_nxt;
  logic                  rsp_valid_nxt;
  logic [RSP_WIDTH-1:0]  rsp_data_nxt;
  logic                  rsp_timeout_nxt;

`ifdef UART_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
`endif

  assign cmd_in = '{typ: cmd_type, addr: cmd_addr, wdata: cmd_wdata,
                    opa: cmd_opa, opb: cmd_opb, fun: cmd_fun};

  // Byte i of the frame for a captured command.
  function automatic logic [DATA_WIDTH-1:0] frame_byte(input cmd_t c, input logic [1:0] i);
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    case (c.typ)
      CMD_RF_WR: begin
        case (i)
          2'd0:    b = HDR_RF_WR;
          2'd1:    b = DATA_WIDTH'(c.addr);
          default: b = c.wdata;
        endcase
      end
      CMD_RF_RD:  b = (i == 2'd0) ? HDR_RF_RD : DATA_WIDTH'(c.addr);
      CMD_ALU_OP: begin
        case (i)
          2'd0:    b = HDR_ALU_OP;
          2'd1:    b = c.opa;
          2'd2:    b = c.opb;
          default: b = DATA_WIDTH'(c.fun);
        endcase
      end
      default:    b = (i == 2'd0) ? HDR_ALU_NOP : DATA_WIDTH'(c.fun);
    endcase
    return b;
  endfunction

  function automatic logic [1:0] frame_last(input logic [1:0] typ);
    case (typ)
      CMD_RF_WR:  return 2'd2;
      CMD_ALU_OP: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

  function automatic logic [BCNT_W-1:0] rsp_len(input logic [1:0] typ);
    return (typ == CMD_RF_RD) ? BCNT_W'(1) : BCNT_W'(RSP_BYTES);
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt       = state;
    cmd_nxt         = cmd_q;
    idx_nxt         = idx_q;
    bcnt_nxt        = bcnt_q;
    acc_nxt         = acc_q;
    tx_valid_nxt    = 1'b0;
    tx_byte_nxt     = tx_byte;
    rsp_valid_nxt   = 1'b0;
    rsp_data_nxt    = rsp_data;
    rsp_timeout_nxt = 1'b0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
    tmo_nxt         = tmo_q;
`endif

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_nxt      = cmd_in;
          idx_nxt      = 2'd0;
          tx_valid_nxt = 1'b1;
          tx_byte_nxt  = frame_byte(cmd_in, 2'd0);
          state_nxt    = S_SEND;
        end
      end

      S_SEND: begin
        tx_valid_nxt = 1'b1;
        if (tx_valid && tx_ready) begin
          if (idx_q == frame_last(cmd_q.typ)) begin
            tx_valid_nxt = 1'b0;
            bcnt_nxt     = '0;
            acc_nxt      = '0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
            tmo_nxt      = '0;
`endif
            if (cmd_q.typ == CMD_RF_WR) begin
              state_nxt     = S_DONE;
              rsp_valid_nxt = 1'b1;
              rsp_data_nxt  = '0;
            end else begin
              state_nxt = S_WAIT_RSP;
            end
          end else begin
            idx_nxt     = idx_q + 2'd1;
            tx_byte_nxt = frame_byte(cmd_q, idx_nxt);
          end
        end
      end

      // A byte arriving on the watchdog's last cycle takes priority over the timeout.
      S_WAIT_RSP: begin
        if (rx_valid) begin
          for (int k = 0; k < RSP_BYTES; k++) begin
            if (bcnt_q == BCNT_W'(k)) acc_nxt[k*DATA_WIDTH +: DATA_WIDTH] = rx_byte;
          end
          bcnt_nxt = bcnt_q + BCNT_W'(1);
`ifdef UART_CMD_MASTER_TIMEOUT_EN
          tmo_nxt  = '0;
`endif
          if (bcnt_nxt == rsp_len(cmd_q.typ)) begin
            state_nxt     = S_DONE;
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = acc_nxt;
          end
        end
`ifdef UART_CMD_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_nxt       = S_DONE;
          rsp_valid_nxt   = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_data_nxt    = acc_q;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
        end
`endif
      end

      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      acc_q       <= '0;
      cmd_ready   <= 1'b0;
      tx_valid    <= 1'b0;
      tx_byte     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cmd_q       <= cmd_nxt;
      idx_q       <= idx_nxt;
      bcnt_q      <= bcnt_nxt;
      acc_q       <= acc_nxt;
      cmd_ready   <= cmd_ready_nxt;
      tx_valid    <= tx_valid_nxt;
      tx_byte     <= tx_byte_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
      rsp_timeout <= rsp_timeout_nxt;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
      tmo_q       <= tmo_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: directed protocol cases plus random commands against a frame/response model.
module tb_uart_cmd_master;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int RW  = 16;
  localparam int TMO = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, cmd_opa, cmd_opb;
  logic [3:0]    cmd_fun;
  logic [DW-1:0] tx_byte;
  logic          tx_valid, tx_ready;
  logic [DW-1:0] rx_byte;
  logic          rx_valid;
  logic          rsp_valid;
  logic [RW-1:0] rsp_data;
  logic          rsp_timeout;

  uart_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_WIDTH(RW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_fun(cmd_fun),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Command under test and its scripted response.
  int          c_typ;
  logic [3:0]  c_addr;
  logic [7:0]  c_wdata, c_opa, c_opb;
  logic [3:0]  c_fun;
  logic [7:0]  rsp_q[$];
  int          stall_mode;
  bit          stray_end;
  int unsigned exp_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int rsp_count(input int typ);
    if (typ == 0) return 0;
    if (typ == 1) return 1;
    return RW / 8;
  endfunction

  // Issue the command, check the frame byte by byte, then return n_send scripted response bytes.
  // Full responses are checked here; partial ones leave exp_acc for the caller.
  task automatic do_cmd(input int n_send);
    logic [7:0] fr[$];
    int         i, cyc, n_exp;
    logic       rdy;
    case (c_typ)
      0:       fr = '{8'hAA, 8'(c_addr), c_wdata};
      1:       fr = '{8'hBB, 8'(c_addr)};
      2:       fr = '{8'hCC, c_opa, c_opb, 8'(c_fun)};
      default: fr = '{8'hDD, 8'(c_fun)};
    endcase
    n_exp = rsp_count(c_typ);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_type  = 2'(c_typ);
    cmd_addr  = c_addr;
    cmd_wdata = c_wdata;
    cmd_opa   = c_opa;
    cmd_opb   = c_opb;
    cmd_fun   = c_fun;
    tick();
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_addr  = 4'($urandom);
    cmd_wdata = 8'($urandom);
    cmd_opa   = 8'($urandom);
    cmd_opb   = 8'($urandom);
    cmd_fun   = 4'($urandom);
    i   = 0;
    cyc = 0;
    while (i < fr.size() && cyc < 200) begin
      check("tx_valid_frame", 32'(tx_valid), 32'd1);
      check("tx_byte_frame", 32'(tx_byte), 32'(fr[i]));
      case (stall_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'(cyc % 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx_ready = rdy;
      if (stray_end && rdy && i == fr.size() - 1) begin
        rx_valid = 1'b1;
        rx_byte  = 8'($urandom);
      end
      tick();
      rx_valid = 1'b0;
      if (rdy) i++;
      cyc++;
    end
    tx_ready = 1'b0;
    if (cyc >= 200) check("tx_budget", 32'd0, 32'd1);
    check("tx_valid_drop", 32'(tx_valid), 32'd0);
    if (n_exp == 0) begin
      check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
      check("wr_rsp_data", 32'(rsp_data), 32'd0);
      check("wr_rsp_timeout", 32'(rsp_timeout), 32'd0);
    end else begin
      exp_acc = 0;
      for (int k = 0; k < n_send; k++) begin
        repeat ($urandom_range(0, 3)) begin
          check("rsp_valid_wait", 32'(rsp_valid), 32'd0);
          tick();
        end
        rx_valid = 1'b1;
        rx_byte  = rsp_q[k];
        exp_acc  = exp_acc + (32'(rsp_q[k]) << (8 * k));
        tick();
        rx_valid = 1'b0;
        if (k < n_exp - 1) check("rsp_valid_early", 32'(rsp_valid), 32'd0);
      end
      if (n_send < n_exp) return;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data", 32'(rsp_data), exp_acc);
      check("rsp_timeout", 32'(rsp_timeout), 32'd0);
      exp_acc = exp_acc;
    end
    tick();
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("post_rsp_hold", 32'(rsp_data), (n_exp == 0) ? 32'd0 : exp_acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  n;
    bit  seen;
    RST = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_wdata = '0;
    cmd_opa = '0; cmd_opb = '0; cmd_fun = '0; tx_ready = 1'b0; rx_byte = '0; rx_valid = 1'b0;
    stall_mode = 0; stray_end = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    RST = 1'b0;
    tick();

    // RF_WR, always ready
    c_typ = 0; c_addr = 4'd3; c_wdata = 8'h5A; stall_mode = 0;
    do_cmd(0);

    // RF_RD returning 0x81
    c_typ = 1; c_addr = 4'd2; rsp_q = '{8'h81};
    do_cmd(1);

    // ALU_OP with tx_ready toggling
    c_typ = 2; c_opa = 8'h10; c_opb = 8'h20; c_fun = 4'd0; rsp_q = '{8'h30, 8'h00}; stall_mode = 1;
    do_cmd(2);
    stall_mode = 0;

    // ALU_NOP with a single response byte
    c_typ = 3; c_fun = 4'd1; rsp_q = '{8'h07, 8'h00};
    do_cmd(1);
`ifdef UART_CMD_MASTER_TIMEOUT_EN
    n = 0;
    while (!rsp_valid && n < TMO + 10) begin
      tick();
      n++;
    end
    check("tmo_latency", 32'(n), 32'(TMO));
    check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tmo_flag", 32'(rsp_timeout), 32'd1);
    check("tmo_partial", 32'(rsp_data), 32'h0007);
    tick();
    check("tmo_cmd_ready", 32'(cmd_ready), 32'd1);
`else
    seen = 1'b0;
    repeat (TMO + 10) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check("no_tmo_wait", 32'(seen), 32'd0);
    rx_valid = 1'b1; rx_byte = 8'h00;
    tick();
    rx_valid = 1'b0;
    check("no_tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    check("no_tmo_flag", 32'(rsp_timeout), 32'd0);
    check("no_tmo_data", 32'(rsp_data), 32'h0007);
    tick();
`endif

    // Second byte lands on the watchdog's final cycle: the byte wins
    c_typ = 3; c_fun = 4'd2; rsp_q = '{8'h44, 8'h9C};
    do_cmd(1);
    seen = 1'b0;
    repeat (TMO - 1) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    if (rsp_valid) seen = 1'b1;
    check("edge_no_early_rsp", 32'(seen), 32'd0);
    rx_valid = 1'b1; rx_byte = 8'h9C;
    tick();
    rx_valid = 1'b0;
    check("edge_rsp_valid", 32'(rsp_valid), 32'd1);
    check("edge_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("edge_rsp_data", 32'(rsp_data), 32'h9C44);
    tick();

    // Stray byte in IDLE, then RF_RD returning 0x11
    rx_valid = 1'b1; rx_byte = 8'hEE;
    tick();
    rx_valid = 1'b0;
    check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    c_typ = 1; c_addr = 4'd5; rsp_q = '{8'h11};
    do_cmd(1);

    // Reset mid-frame during ALU_OP
    cmd_valid = 1'b1; cmd_type = 2'd2; cmd_opa = 8'h12; cmd_opb = 8'h34; cmd_fun = 4'd3;
    tick();
    cmd_valid = 1'b0; tx_ready = 1'b1;
    tick();
    tick();
    check("rst_mid_byte2", 32'(tx_byte), 32'h34);
    RST = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    RST = 1'b0;
    tick();
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    seen = 1'b0;
    repeat (5) begin
      if (rsp_valid || tx_valid) seen = 1'b1;
      tick();
    end
    check("rst_mid_quiet", 32'(seen), 32'd0);
    c_typ = 1; c_addr = 4'd9; rsp_q = '{8'hC3};
    do_cmd(1);

    // Random commands, stalls and stray bytes
    for (int r = 0; r < 40; r++) begin
      c_typ      = int'($urandom_range(0, 3));
      c_addr     = 4'($urandom);
      c_wdata    = 8'($urandom);
      c_opa      = 8'($urandom);
      c_opb      = 8'($urandom);
      c_fun      = 4'($urandom);
      rsp_q      = '{8'($urandom), 8'($urandom)};
      stall_mode = int'($urandom_range(0, 2));
      stray_end  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        rx_valid = 1'b1; rx_byte = 8'($urandom);
        tick();
        rx_valid = 1'b0;
      end
      do_cmd(rsp_count(c_typ));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_master.md
Name: uart_cmd_master

Overview:
- Host-side command initiator for the UART register-file/ALU command protocol; the requesting end of the frames the system controller decodes.
- Accepts one command at a time on a valid/ready interface and serializes it into frame bytes toward a UART transmitter front end.
- Collects the response bytes from a UART receiver front end and presents one assembled response word.
- Used in host bridges and as the bench driver for the system top.

Parameters:
- DATA_WIDTH, 8, byte width on the tx/rx byte interfaces and of addr, wdata and operands.
- ADDR_WIDTH, 4, register-file address width; zero-extended into a byte on the wire.
- RSP_WIDTH, 16, ALU result width; a response is RSP_WIDTH/8 bytes, LSB first.
- TIMEOUT, 4096, CLK cycles allowed between response bytes before aborting.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_type  in  2  0=RF_WR, 1=RF_RD, 2=ALU_OP, 3=ALU_NOP
- cmd_addr  in  ADDR_WIDTH  register address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_opa  in  DATA_WIDTH  ALU operand A
- cmd_opb  in  DATA_WIDTH  ALU operand B
- cmd_fun  in  4  ALU function
- tx_byte  out  DATA_WIDTH  frame byte
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  UART TX accepts the byte this cycle
- rx_byte  in  DATA_WIDTH  response byte
- rx_valid  in  1  one-cycle strobe per received byte
- rsp_valid  out  1  one-cycle pulse: command complete
- rsp_data  out  RSP_WIDTH  assembled response, zero-extended
- rsp_timeout  out  1  qualifies rsp_valid: response timed out

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1 in IDLE. tx_valid=0, tx_byte=0, rsp_valid=0, rsp_data=0, rsp_timeout=0. Counters cleared, state=IDLE.
- Frames, sent in order:
  - RF_WR: 0xAA, addr, wdata. No response expected.
  - RF_RD: 0xBB, addr. 1 response byte expected.
  - ALU_OP: 0xCC, opa, opb, fun. RSP_WIDTH/8 response bytes expected.
  - ALU_NOP: 0xDD, fun. RSP_WIDTH/8 response bytes expected.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture all cmd_* fields and go to SEND. The handshake takes one cycle.
  - Captured fields are held until the command completes, so later input changes are ignored.
- State SEND:
  - tx_valid=1 with tx_byte=frame[idx]. tx_byte and tx_valid are registered.
  - idx advances only on a cycle where tx_valid&tx_ready.
  - tx_byte stays stable while tx_valid=1 and tx_ready=0.
  - After the last byte is accepted: tx_valid drops the next cycle.
  - For RF_WR, go to DONE with rsp_data=0. Otherwise go to WAIT_RSP with the byte count and timeout counter cleared.
- State WAIT_RSP:
  - Each rx_valid shifts rx_byte into the response: byte k lands in bits [8k+7:8k].
  - The timeout counter resets on every rx_valid.
  - When the expected byte count is reached, go to DONE.
  - If the counter reaches TIMEOUT-1 with no byte, go to DONE with rsp_timeout=1. rsp_data then holds the partial bytes received, with the rest zero.
- State DONE:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_data holds its value until the next DONE.
  - rsp_timeout is valid only with rsp_valid and is 0 otherwise.
- Latency: cmd_valid to first tx_valid is 1 cycle. Last rx_valid to rsp_valid is 1 cycle. After rsp_valid, cmd_ready=1 on the next cycle.
- Stray rx bytes: rx_valid in IDLE, SEND or DONE is discarded. A byte arriving in the same cycle as the final tx acceptance is also discarded.
- rx_valid in the same cycle the timeout fires: the byte wins. It is stored, the counter resets and no timeout occurs.
- RST asserted mid-frame: next cycle tx_valid=0 and state=IDLE; the partial frame is abandoned and no rsp_valid is issued.
- cmd_addr is zero-extended to DATA_WIDTH on the wire.

Optional Feature:
- Macro: UART_CMD_MASTER_TIMEOUT_EN.
- Defined: the timeout watchdog operates as described, and rsp_timeout can be 1.
- Undefined: no timeout counter is built, WAIT_RSP waits indefinitely, and rsp_timeout is tied to 0.

Test Plan:
- RF_WR addr=3, wdata=0x5A, tx_ready held 1 -> tx_byte 0xAA, 0x03, 0x5A on 3 consecutive cycles. Then rsp_valid=1 with rsp_data=0x0000 and rsp_timeout=0.
- RF_RD addr=2, responder returns 0x81 -> frame 0xBB, 0x02. Then rsp_data=0x0081 one cycle after rx_valid.
- ALU_OP opa=0x10, opb=0x20, fun=0, tx_ready toggling 1/0 -> 0xCC, 0x10, 0x20, 0x00 sent, each byte held stable while stalled. Response bytes 0x30, 0x00 give rsp_data=0x0030.
- ALU_NOP fun=1 with only one response byte 0x07 (macro defined) -> TIMEOUT cycles after it, rsp_valid=1, rsp_timeout=1, rsp_data=0x0007.
- rx_valid=1 with byte 0xEE while in IDLE, then RF_RD returning 0x11 -> rsp_data=0x0011; the stray byte is ignored.
- RST pulsed after the second byte of ALU_OP -> tx_valid=0 next cycle, no rsp_valid, cmd_ready=1 once RST deasserts; a following RF_RD completes normally.
